multicycle_control_fsm: RTL and testbench

//  Moore FSM that sequences the multi-cycle RV32I datapath: fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: Moore outputs from the state register; ir_write/pc_write in FETCH also need mem_ready_i.
// Backpressure: stalls in a request state until mem_ready_i; bus timeout or illegal opcode -> sticky FAULT.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   opcode_i, zero_i, mem_ready_i IR opcode, ALU zero flag (unused here), memory completion
//   mem_req_o, mem_we_o           memory request / write qualifier
//   addr_src_o, ir_write_o, pc_write_o, pc_write_cond_o, reg_write_o   datapath enables/selects
//   alu_src_a_o, alu_src_b_o, ALU_CO_o, is_immediate_o, result_src_o   ALU operand/op/result selects
//   fault_o, state_o              sticky fault flag, current state for debug
module multicycle_control_fsm #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] ALU_CO_o,
  output logic       is_immediate_o,
  output logic [1:0] result_src_o,
  output logic       fault_o,
  output logic [3:0] state_o
);

  // Counter is at least 8 bits, wider if the timeout needs it.
  localparam int CW = ($clog2(BUS_TIMEOUT + 1) > 8) ? $clog2(BUS_TIMEOUT + 1) : 8;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_JAL_LINK  = 4'd14,
    S_FAULT     = 4'd15
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_hit;

  // Branch decision is applied outside this block via pc_write_cond_o.
  logic unused_zero;
  assign unused_zero = zero_i;

  // Expiry on the last allowed wait cycle; a concurrent mem_ready_i takes priority in the FSM.
  assign tmo_hit = (BUS_TIMEOUT != 0) && mem_req_o && !mem_ready_i &&
                   (tmo_cnt == CW'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_FETCH;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tmo_cnt <= '0;
      end else if (mem_req_o && !mem_ready_i && (tmo_cnt != '1)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    addr_src_o      = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    ALU_CO_o        = 2'b00;
    is_immediate_o  = 1'b0;
    result_src_o    = 2'b00;
    fault_o         = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_nxt  = S_DECODE;
        end else if (tmo_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut while dispatching.
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        case (opcode_i)
          7'b0000011, 7'b0100011: state_nxt = S_MEM_ADDR;
          7'b0110011:             state_nxt = S_EXEC_R;
          7'b0010011:             state_nxt = S_EXEC_I;
          7'b1100011:             state_nxt = S_BRANCH;
          7'b1101111:             state_nxt = S_JAL;
          7'b1100111:             state_nxt = S_JALR;
          7'b0110111:             state_nxt = S_LUI;
          7'b0010111:             state_nxt = S_AUIPC;
          default:                state_nxt = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        // opcode bit 5 separates store (0100011) from load (0000011).
        state_nxt   = opcode_i[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_o  = 1'b1;
        addr_src_o = 1'b1;
        if (mem_ready_i)  state_nxt = S_MEM_WB;
        else if (tmo_hit) state_nxt = S_FAULT;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'b01;
        state_nxt    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        addr_src_o = 1'b1;
        if (mem_ready_i)  state_nxt = S_FETCH;
        else if (tmo_hit) state_nxt = S_FAULT;
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b01;
        ALU_CO_o    = 2'b10;
        state_nxt   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_o    = 2'b01;
        alu_src_b_o    = 2'b01;
        ALU_CO_o       = 2'b10;
        is_immediate_o = 1'b1;
        state_nxt      = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o     = 2'b01;
        ALU_CO_o        = 2'b01;
        pc_write_cond_o = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
        reg_write_o = 1'b1;
        pc_write_o  = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_JALR: begin
        // Jump target goes straight from the ALU into PC; link written next cycle.
        alu_src_a_o  = 2'b01;
        alu_src_b_o  = 2'b01;
        pc_write_o   = 1'b1;
        result_src_o = 2'b10;
        state_nxt    = S_JAL_LINK;
      end
      S_JAL_LINK: begin
        alu_src_a_o  = 2'b10;
        alu_src_b_o  = 2'b10;
        reg_write_o  = 1'b1;
        result_src_o = 2'b10;
        state_nxt    = S_FETCH;
      end
      S_LUI: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        state_nxt   = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_nxt   = S_ALU_WB;
      end
      S_FAULT: begin
        fault_o = 1'b1;
      end
      default: state_nxt = S_FAULT;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: per-instruction expected state sequences built
// from the instruction class and chosen memory wait states, compared cycle by cycle.
module tb_multicycle_control_fsm;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] opcode_i = 7'd0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_we_o, addr_src_o, ir_write_o, pc_write_o;
  logic       pc_write_cond_o, reg_write_o, is_immediate_o, fault_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, ALU_CO_o, result_src_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  int st_q[$];
  bit rd_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.BUS_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .addr_src_o(addr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_write_cond_o(pc_write_cond_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .ALU_CO_o(ALU_CO_o),
    .is_immediate_o(is_immediate_o), .result_src_o(result_src_o),
    .fault_o(fault_o), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output table straight from the state descriptions.
  // Order: req we addr irw pcw pcwc regw srca srcb co imm res fault
  function automatic logic [16:0] exp_out(input int st, input bit rdy);
    logic req = 0, we = 0, adr = 0, irw = 0, pcw = 0, pcc = 0, rgw = 0, imm = 0, flt = 0;
    logic [1:0] sa = 0, sb = 0, co = 0, rs = 0;
    case (st)
      0:  begin req = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy; end
      1:  begin sa = 2; sb = 1; end
      2:  begin sa = 1; sb = 1; end
      3:  begin req = 1; adr = 1; end
      4:  begin rgw = 1; rs = 1; end
      5:  begin req = 1; we = 1; adr = 1; end
      6:  begin sa = 1; sb = 0; co = 2; end
      7:  begin sa = 1; sb = 1; co = 2; imm = 1; end
      8:  begin rgw = 1; rs = 0; end
      9:  begin sa = 1; sb = 0; co = 1; pcc = 1; end
      10: begin sa = 2; sb = 2; rgw = 1; pcw = 1; end
      11: begin sa = 1; sb = 1; pcw = 1; rs = 2; end
      12: begin sa = 1; sb = 1; end
      13: begin sa = 2; sb = 1; end
      14: begin sa = 2; sb = 2; rgw = 1; rs = 2; end
      default: flt = 1;
    endcase
    return {req, we, adr, irw, pcw, pcc, rgw, sa, sb, co, imm, rs, flt};
  endfunction

  function automatic logic [16:0] dut_out();
    return {mem_req_o, mem_we_o, addr_src_o, ir_write_o, pc_write_o, pc_write_cond_o,
            reg_write_o, alu_src_a_o, alu_src_b_o, ALU_CO_o, is_immediate_o,
            result_src_o, fault_o};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Memory access of d wait states; d >= TO means the bus never answers in time.
  task automatic push_access(input int st, input int d, inout bit flt);
    for (int i = 0; i < d && i < TO; i++) begin st_q.push_back(st); rd_q.push_back(1'b0); end
    if (d < TO) begin st_q.push_back(st); rd_q.push_back(1'b1); end
    else flt = 1'b1;
  endtask

  task automatic push_plain(input int st);
    st_q.push_back(st);
    rd_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Runs one instruction from FETCH. abort_k >= 0 asserts rst_i at that cycle index.
  task automatic run_instr(input logic [6:0] op, input int d_f, input int d_m, input int abort_k);
    bit flt = 1'b0;
    st_q.delete();
    rd_q.delete();
    push_access(0, d_f, flt);
    if (!flt) begin
      push_plain(1);
      case (op)
        7'b0000011: begin push_plain(2); push_access(3, d_m, flt); if (!flt) push_plain(4); end
        7'b0100011: begin push_plain(2); push_access(5, d_m, flt); end
        7'b0110011: begin push_plain(6); push_plain(8); end
        7'b0010011: begin push_plain(7); push_plain(8); end
        7'b1100011: push_plain(9);
        7'b1101111: push_plain(10);
        7'b1100111: begin push_plain(11); push_plain(14); end
        7'b0110111: begin push_plain(12); push_plain(8); end
        7'b0010111: begin push_plain(13); push_plain(8); end
        default:    flt = 1'b1;
      endcase
    end
    if (flt) for (int i = 0; i < 11; i++) push_plain(15);

    for (int k = 0; k < st_q.size(); k++) begin
      bit last_rst;
      last_rst = (k == abort_k) || (flt && k == st_q.size() - 1);
      mem_ready_i = rd_q[k];
      opcode_i    = (st_q[k] == 0) ? 7'($urandom) : op;
      zero_i      = 1'($urandom_range(0, 1));
      #1;
      chk("state", 32'(state_o), 32'(st_q[k]));
      chk("outputs", 32'(dut_out()), 32'(exp_out(st_q[k], rd_q[k])));
      rst_i = last_rst;
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      if (last_rst) break;
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] legal [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [6:0] op;
    if ($urandom_range(0, 9) != 0) return legal[$urandom_range(0, 8)];
    do op = 7'($urandom); while (is_legal(op));
    return op;
  endfunction

  function automatic int rand_delay();
    return ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
  endfunction

  initial begin
    rst_i = 1'b1;
    mem_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outputs", 32'(dut_out()), 32'(exp_out(0, 1'b1)));
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    @(negedge clk);

    run_instr(7'b0110011, 0, 0, -1);   // ADD
    run_instr(7'b0000011, 0, 3, -1);   // LW, delayed read
    run_instr(7'b0100011, 0, 1, -1);   // SW
    run_instr(7'b1100011, 0, 0, -1);   // BEQ
    run_instr(7'b1101111, 0, 0, -1);   // JAL
    run_instr(7'b1100111, 0, 0, -1);   // JALR
    run_instr(7'b0110111, 0, 0, -1);   // LUI
    run_instr(7'b0010111, 0, 0, -1);   // AUIPC
    run_instr(7'b0010011, 2, 0, -1);   // ADDI, delayed fetch
    run_instr(7'b1111111, 0, 0, -1);   // illegal -> FAULT, then reset
    run_instr(7'b0110011, TO, 0, -1);  // fetch timeout
    run_instr(7'b0110011, TO - 1, 0, -1); // ready on last allowed cycle
    run_instr(7'b0100011, 1, TO, -1);  // store timeout
    run_instr(7'b0000011, 3, 3, -1);   // counter must clear between accesses
    run_instr(7'b0000011, 0, 3, 4);    // reset mid read access

    for (int n = 0; n < 400; n++) begin
      int ab;
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(rand_op(), rand_delay(), rand_delay(), ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
